cpu_datapath: RTL and testbench

Downstream consumer of the 8-bit CPU microcode decoder's control word. Holds the architectural state: program counter, MAR, 16x8 RAM, instruction register, A, B, ALU and output register. Arbitrates the shared 8-bit bus. Returns the fetched instruction byte to the decoder. Control inputs change on the falling clock edge. All register loads happen on the rising edge.

---
 rtl/cpu_datapath.sv | 131 +++++++++++++
 tb/tb_cpu_datapath.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Architectural datapath for the 8-bit microcoded CPU: PC, MAR, RAM, IR, A, B, ALU, OUT
// and the shared bus, driven by the decoder's one-hot-ish control word.
module cpu_datapath #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              mi,
    input  logic              ri,
    input  logic              ro,
    input  logic              io,
    input  logic              ii,
    input  logic              ai,
    input  logic              ao,
    input  logic              sumo,
    input  logic              sub,
    input  logic              bi,
    input  logic              oi,
    input  logic              ce,
    input  logic              co,
    input  logic              j,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] insn,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] out_val,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic              bus_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] out_reg;

    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;
    logic [2:0]        drv_cnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Subtraction is A + ~B + 1, so the carry out doubles as "A >= B".
    assign alu_sum = {1'b0, a_reg} + {1'b0, (sub ? ~b_reg : b_reg)} + {{DATA_W{1'b0}}, sub};
    assign alu_r   = alu_sum[DATA_W-1:0];
    assign alu_c   = alu_sum[DATA_W];

    always_comb begin
        bus = '0;
        if (co)
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        else if (ro)
            bus = mem[mar];
        else if (io)
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        else if (ao)
            bus = a_reg;
        else if (sumo)
            bus = alu_r;
    end

    always_comb begin
        drv_cnt = {2'b00, co} + {2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, sumo};
    end

    assign bus_conflict = (drv_cnt >= 3'd2);

    // RAM write port is shared between program loading (only while in reset) and ri.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = mar;
        mem_wd = bus;
        if (rst) begin
            mem_we = prog_we;
            mem_wa = prog_addr;
            mem_wd = prog_data;
        end else begin
            mem_we = ri & ~halted;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            out_reg <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            halted  <= 1'b0;
        end else if (!halted) begin
            if (mi) mar     <= bus[ADDR_W-1:0];
            if (ii) ir      <= bus;
            if (ai) a_reg   <= bus;
            if (bi) b_reg   <= bus;
            if (oi) out_reg <= bus;
            if (sumo) begin
                carry <= alu_c;
                zero  <= (alu_r == '0);
            end
            if (j)
                pc <= bus[ADDR_W-1:0];
            else if (ce)
                pc <= pc + 1'b1;
            if (hlt) halted <= 1'b1;
        end
    end

    assign insn    = ir;
    assign out_val = out_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed program/ALU/PC/bus/halt steps plus random control words,
// every cycle compared against a behavioural model of the architectural state.
module tb_cpu_datapath;

    localparam logic [14:0] HLT  = 15'h0001;
    localparam logic [14:0] MI   = 15'h0002;
    localparam logic [14:0] RI   = 15'h0004;
    localparam logic [14:0] RO   = 15'h0008;
    localparam logic [14:0] IO   = 15'h0010;
    localparam logic [14:0] II   = 15'h0020;
    localparam logic [14:0] AI   = 15'h0040;
    localparam logic [14:0] AO   = 15'h0080;
    localparam logic [14:0] SUMO = 15'h0100;
    localparam logic [14:0] SUB  = 15'h0200;
    localparam logic [14:0] BI   = 15'h0400;
    localparam logic [14:0] OI   = 15'h0800;
    localparam logic [14:0] CE   = 15'h1000;
    localparam logic [14:0] CO   = 15'h2000;
    localparam logic [14:0] J    = 15'h4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hlt = 0, mi = 0, ri = 0, ro = 0, io = 0, ii = 0, ai = 0, ao = 0;
    logic sumo = 0, sub = 0, bi = 0, oi = 0, ce = 0, co = 0, j = 0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'h0;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] insn, bus, out_val;
    logic [3:0] pc;
    logic       carry, zero, halted, bus_conflict;

    int checks = 0;
    int failures = 0;

    // Reference architectural state
    logic [7:0] m_mem [0:15];
    logic [3:0] m_pc = 0, m_mar = 0;
    logic [7:0] m_ir = 0, m_a = 0, m_b = 0, m_out = 0;
    logic       m_c = 0, m_z = 0, m_h = 0;

    cpu_datapath dut (
        .clk(clk), .rst(rst), .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii),
        .ai(ai), .ao(ao), .sumo(sumo), .sub(sub), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .insn(insn), .bus(bus), .out_val(out_val), .pc(pc), .carry(carry), .zero(zero),
        .halted(halted), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [14:0] cw);
        hlt = cw[0];  mi = cw[1];  ri = cw[2];   ro = cw[3];   io = cw[4];
        ii = cw[5];   ai = cw[6];  ao = cw[7];   sumo = cw[8]; sub = cw[9];
        bi = cw[10];  oi = cw[11]; ce = cw[12];  co = cw[13];  j = cw[14];
    endtask

    // ALU from plain arithmetic: bit 8 is the carry, low byte the result.
    function automatic logic [8:0] ref_alu(input logic s);
        int x;
        if (!s) x = int'(m_a) + int'(m_b);
        else    x = int'(m_a) - int'(m_b) + 256;
        return x[8:0];
    endfunction

    function automatic logic [7:0] ref_bus(input logic [14:0] cw);
        logic [8:0] al;
        al = ref_alu((cw & SUB) != 0);
        if ((cw & CO) != 0)   return {4'h0, m_pc};
        if ((cw & RO) != 0)   return m_mem[m_mar];
        if ((cw & IO) != 0)   return {4'h0, m_ir[3:0]};
        if ((cw & AO) != 0)   return m_a;
        if ((cw & SUMO) != 0) return al[7:0];
        return 8'h00;
    endfunction

    task automatic model_step(input logic [14:0] cw, input logic [7:0] b);
        logic [8:0] al;
        if (rst) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
        end else if (!m_h) begin
            al = ref_alu((cw & SUB) != 0);
            if ((cw & RI) != 0) m_mem[m_mar] = b;
            if ((cw & MI) != 0) m_mar = b[3:0];
            if ((cw & II) != 0) m_ir = b;
            if ((cw & AI) != 0) m_a = b;
            if ((cw & BI) != 0) m_b = b;
            if ((cw & OI) != 0) m_out = b;
            if ((cw & SUMO) != 0) begin
                m_c = al[8];
                m_z = (al[7:0] == 8'h00);
            end
            if ((cw & J) != 0)       m_pc = b[3:0];
            else if ((cw & CE) != 0) m_pc = 4'((int'(m_pc) + 1) % 16);
            if ((cw & HLT) != 0) m_h = 1'b1;
        end
    endtask

    task automatic chk_regs();
        chk("insn", insn, m_ir);
        chk("out_val", out_val, m_out);
        chk("pc", {4'h0, pc}, {4'h0, m_pc});
        chk("carry", {7'h0, carry}, {7'h0, m_c});
        chk("zero", {7'h0, zero}, {7'h0, m_z});
        chk("halted", {7'h0, halted}, {7'h0, m_h});
    endtask

    // One clock: controls change on the falling edge, registers checked just after the rising edge.
    task automatic cycle(input logic [14:0] cw);
        logic [7:0] eb;
        @(negedge clk);
        drive(cw);
        #1;
        eb = ref_bus(cw);
        chk("bus", bus, eb);
        chk("bus_conflict", {7'h0, bus_conflict},
            {7'h0, ($countones(cw & (CO | RO | IO | AO | SUMO)) >= 2)});
        @(posedge clk);
        model_step(cw, eb);
        #1;
        chk_regs();
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        prog_we = 1'b1;
        prog_addr = addr;
        prog_data = data;
        cycle(15'h0);
        prog_we = 1'b0;
    endtask

    // Raise rst between clock edges with cw applied and verify the clear is immediate.
    task automatic do_reset(input logic [14:0] cw);
        @(negedge clk);
        drive(cw);
        #2;
        rst = 1'b1;
        #1;
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
        m_c = 0; m_z = 0; m_h = 0;
        chk_regs();
        chk("rst_bus", bus, ref_bus(cw));
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        drive(15'h0);
    endtask

    task automatic repeat_cycle(input logic [14:0] cw, input int n);
        for (int k = 0; k < n; k++) cycle(cw);
    endtask

    initial begin
        logic [14:0] cw;
        int hold;

        #1 rst = 1'b1;
        for (int i = 0; i < 16; i++)
            prog(4'(i), (i == 3) ? 8'h55 : 8'($urandom));
        release_rst();

        // Async reset mid-run with A=0x55, PC=7; RAM survives.
        repeat_cycle(CE, 3);
        cycle(CO | MI);
        cycle(RO | AI);
        repeat_cycle(CE, 4);
        cycle(AO);
        chk("t1_a_before", bus, 8'h55);
        chk("t1_pc_before", {4'h0, pc}, 8'h07);
        do_reset(15'h0);
        chk("t1_pc_rst", {4'h0, pc}, 8'h00);
        chk("t1_bus_rst", bus, 8'h00);
        release_rst();
        repeat_cycle(CE, 3);
        cycle(CO | MI);
        cycle(RO);
        chk("t1_ram3", bus, 8'h55);

        // LDA 14 / ADD 15 / OUT / HLT, with a mid-instruction abort on entry.
        do_reset(RO | AI | CE | MI);
        prog(4'd0, 8'h1E); prog(4'd1, 8'h2F); prog(4'd2, 8'hE0);
        prog(4'd3, 8'hF0); prog(4'd14, 8'h1C); prog(4'd15, 8'h0E);
        release_rst();
        cycle(CO | MI); cycle(RO | II | CE); cycle(IO | MI); cycle(RO | AI);
        cycle(CO | MI); cycle(RO | II | CE); cycle(IO | MI); cycle(RO | BI); cycle(SUMO | AI);
        cycle(CO | MI); cycle(RO | II | CE); cycle(AO | OI);
        cycle(CO | MI); cycle(RO | II | CE); cycle(HLT);
        chk("t2_out", out_val, 8'h2A);
        chk("t2_carry", {7'h0, carry}, 8'h00);
        chk("t2_zero", {7'h0, zero}, 8'h00);
        chk("t2_halted", {7'h0, halted}, 8'h01);
        chk("t2_pc", {4'h0, pc}, 8'h04);
        chk("t2_insn", insn, 8'hF0);

        // Controls asserted during reset must be ignored.
        do_reset(15'h0);
        prog(4'd0, 8'h03); prog(4'd1, 8'h05); prog(4'd2, 8'h09);
        prog(4'd5, 8'h77); prog(4'd6, 8'h33);
        cycle(AI | CE | RI | CO | MI | HLT);
        chk("rst_ignore_pc", {4'h0, pc}, 8'h00);
        release_rst();

        // ALU subtract: 3-5 then 5-5.
        cycle(RO | AI); cycle(CE); cycle(CO | MI); cycle(RO | BI);
        cycle(SUMO | SUB | AI);
        cycle(AO);
        chk("t3_a_fe", bus, 8'hFE);
        chk("t3_carry0", {7'h0, carry}, 8'h00);
        chk("t3_zero0", {7'h0, zero}, 8'h00);
        cycle(RO | AI);
        cycle(SUMO | SUB | AI);
        cycle(AO);
        chk("t3_a_00", bus, 8'h00);
        chk("t3_carry1", {7'h0, carry}, 8'h01);
        chk("t3_zero1", {7'h0, zero}, 8'h01);

        // Jump beats increment; PC wraps 15 -> 0.
        cycle(CE); cycle(CO | MI); cycle(RO | AI); repeat_cycle(CE, 2);
        chk("t4_pc4", {4'h0, pc}, 8'h04);
        cycle(CE | J | AO);
        chk("t4_jump", {4'h0, pc}, 8'h09);
        repeat_cycle(CE, 6);
        chk("t4_pc15", {4'h0, pc}, 8'h0F);
        cycle(CE);
        chk("t4_wrap", {4'h0, pc}, 8'h00);

        // Bus priority and conflict.
        repeat_cycle(CE, 5); cycle(CO | MI); cycle(RO | AI);
        cycle(CO | AO);
        chk("t5_bus_pri", bus, 8'h05);
        chk("t5_conflict", {7'h0, bus_conflict}, 8'h01);
        cycle(15'h0);
        chk("t5_bus_idle", bus, 8'h00);
        chk("t5_no_conflict", {7'h0, bus_conflict}, 8'h00);

        // Halt freezes state; the load issued alongside hlt still lands.
        cycle(CE); cycle(CO | MI);
        cycle(HLT | AO | OI);
        chk("t6_out_with_hlt", out_val, 8'h77);
        repeat_cycle(RO | AI | CE | RI, 3);
        chk("t6_pc_frozen", {4'h0, pc}, 8'h06);
        cycle(AO);
        chk("t6_a_frozen", bus, 8'h77);
        cycle(AO | RI);
        cycle(RO);
        chk("t6_ram_frozen", bus, 8'h33);
        do_reset(15'h0);
        chk("t6_unhalt", {7'h0, halted}, 8'h00);
        release_rst();

        // Random control words against the model, with occasional resets.
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if ((m_h && hold > 3) || $urandom_range(0, 99) == 0) begin
                do_reset(15'($urandom) & 15'($urandom));
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    prog(4'($urandom), 8'($urandom));
                release_rst();
                hold = 0;
            end
            cw = 15'($urandom) & 15'($urandom) & 15'h7FFE;
            if ($urandom_range(0, 39) == 0) cw = cw | HLT;
            cycle(cw);
            if (m_h) hold++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
